fp_norm_scheduler: RTL

- Shares one 24-bit leading-zero-detect + left-shift normalizer between NUM_REQ floating-point lanes (adder/MAC post-subtract results) in the AI accelerator FP datapath.
- Round-robin arbitrates valid/ready requests and pushes the winner through a 2-stage pipeline: capture, then LZD/shift/exponent adjust.
- Returns the normalized mantissa/exponent on a single tagged response channel with backpressure.

---
 rtl/fp_norm_pkg.sv | 21 ++
 rtl/fp_norm_scheduler_rr_arbiter.sv | 38 +++
 rtl/fp_norm_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared widths and request/response records for the FP normalizer scheduler.
package fp_norm_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int LZ_W   = 5;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
    } norm_req_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero;
        logic              uflow;
    } norm_rsp_t;
endpackage

// File: rtl/fp_norm_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_REQ lanes; the pointer moves just past each winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_any,
    output logic [ID_W-1:0]    grant_id
);
    logic [ID_W-1:0] ptr;
    int idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (en && !grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (grant_any)
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
endmodule

// File: rtl/fp_norm_scheduler.sv
// fp_norm_scheduler: round-robin shares one LZD/left-shift normalizer between NUM_REQ FP lanes
// through a capture stage and a normalize stage with a backpressured tagged response.
module fp_norm_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MANT_W  = 24,
    parameter int EXP_W   = 8,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*MANT_W-1:0]  req_mant,
    input  logic [NUM_REQ*EXP_W-1:0]   req_exp,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [MANT_W-1:0]          rsp_mant,
    output logic [EXP_W-1:0]           rsp_exp,
    output logic                       rsp_zero,
    output logic                       rsp_uflow
);
    import fp_norm_pkg::*;

    logic               adv1, adv2, s1_valid, grant_any, zero, clamp;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gid;
    logic [LZ_W-1:0]    lz;
    logic [EXP_W:0]     exp_x, lz_x;
    norm_req_t          s1, cap;
    norm_rsp_t          rsp, nxt;

    // The highest set bit is found last, so it decides the count.
    function automatic logic [LZ_W-1:0] lzc(input logic [MANT_W-1:0] m);
        lzc = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++)
            if (m[i]) lzc = LZ_W'(MANT_W - 1 - i);
    endfunction

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (adv1 && !rst),
        .req       (req_valid),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_id  (gid)
    );

    assign req_ready = grant;
    assign cap.id    = gid;
    assign cap.mant  = req_mant[gid*MANT_W +: MANT_W];
    assign cap.exp   = req_exp[gid*EXP_W +: EXP_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (adv1) begin
            s1_valid <= grant_any;
            s1       <= cap;
        end
    end

    // Clamp shifts only by the exponent so the result lands exactly at exponent 0.
    always_comb begin
        lz       = lzc(s1.mant);
        exp_x    = {1'b0, s1.exp};
        lz_x     = (EXP_W+1)'(lz);
        zero     = s1.mant == '0;
        clamp    = !zero && lz_x >= exp_x;
        nxt.id   = s1.id;
        nxt.mant = zero ? '0 : clamp ? s1.mant << s1.exp : s1.mant << lz;
        nxt.exp  = (zero || clamp) ? '0 : EXP_W'(exp_x - lz_x);
        nxt.zero = zero;
        nxt.uflow = clamp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
        end else if (adv2) begin
            rsp_valid <= s1_valid;
            rsp       <= nxt;
        end
    end

    assign rsp_id    = rsp.id;
    assign rsp_mant  = rsp.mant;
    assign rsp_exp   = rsp.exp;
    assign rsp_zero  = rsp.zero;
    assign rsp_uflow = rsp.uflow;
endmodule
